// File: rtl/bram_buffered_pkg.sv
// Shared constants and elaboration-time helpers for the buffered block-RAM.
package bram_pkg;

    localparam int BRAM_WR_OLD = 0;
    localparam int BRAM_WR_NEW = 1;

    function automatic int bramLaneWidth(input int dataSize, input int numLanes);
        return dataSize / numLanes;
    endfunction

    // The response buffer must absorb every read still in the pipeline plus the one being presented.
    function automatic bit bramParamsOk(input int dataSize, input int numLanes, input int addrSize,
                                        input int numRows, input int outRegs, input int bufDepth);
        return (numLanes > 0) && (dataSize > 0) && ((dataSize % numLanes) == 0) &&
               ((outRegs == 0) || (outRegs == 1)) && (bufDepth >= outRegs + 2) &&
               (numRows > 0) && (numRows <= (1 << addrSize));
    endfunction

endpackage

// File: rtl/bram_buffered_resp_fifo.sv
// First-word-fall-through response FIFO; only pointers and occupancy are reset.
module bram_resp_fifo #(
    parameter int dataSize = 32,
    parameter int depth    = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_push,
    input  logic [dataSize-1:0]            i_data,
    input  logic                           i_pop,
    output logic [dataSize-1:0]            o_data,
    output logic                           o_empty,
    output logic [$clog2(depth+1)-1:0]     o_count
);
    localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
    localparam int CNT_W = $clog2(depth + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(depth - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(depth);

    logic [dataSize-1:0] r_mem [depth];
    logic [PTR_W-1:0]    r_wrPtr;
    logic [PTR_W-1:0]    r_rdPtr;
    logic [CNT_W-1:0]    r_count;
    logic                w_push;
    logic                w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != FULL_CNT) || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wrPtr] <= i_data;
    end

    assign o_data  = r_mem[r_rdPtr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/bram_buffered.sv
// Block RAM with lane-masked writes, optional output register and a credit-controlled response buffer.
module bram_buffered
    import bram_pkg::*;
#(
    parameter int dataSize = 32,
    parameter int addrSize = 9,
    parameter int numRows  = 512,
    parameter int numLanes = 4,
    parameter int outRegs  = 0,
    parameter int bufDepth = 4,
    parameter int wrMode   = BRAM_WR_OLD
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                readEnable,
    input  logic [addrSize-1:0] readAddr,
    output logic                readReady,
    output logic [dataSize-1:0] readData,
    input  logic                readDataEnable,
    output logic                readDataReady,
    input  logic                writeEnable,
    input  logic [addrSize-1:0] writeAddr,
    input  logic [dataSize-1:0] writeData,
    input  logic [numLanes-1:0] writeMask,
    output logic                writeReady,
    output logic                noPendingBool
);
    localparam int LANE_W = bramLaneWidth(dataSize, numLanes);
    localparam int CNT_W  = $clog2(bufDepth + 1);
    localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(bufDepth);
    localparam logic [addrSize:0] ROWS_C  = (addrSize + 1)'(numRows);

    if (!bramParamsOk(dataSize, numLanes, addrSize, numRows, outRegs, bufDepth)) begin : gBadParams
        $error("bram_buffered: illegal dataSize/numLanes/bufDepth/outRegs combination");
    end

    (* ram_style = "block" *) logic [dataSize-1:0] r_mem [numRows];

    logic                w_accept, w_wrAccept, w_rdHit;
    logic [dataSize-1:0] w_rdWord;
    logic                r_v0;
    logic [dataSize-1:0] r_q0;
    logic                w_lastValid;
    logic [dataSize-1:0] w_lastData;
    logic [CNT_W-1:0]    r_inFlight, w_inFlightNext, w_fifoCount, w_countNext;
    logic                w_fifoEmpty, w_pop, w_fifoPush, w_fifoPop;
    logic [dataSize-1:0] w_fifoData;
    logic                r_noPending;

    assign readReady  = !RST && (({1'b0, r_inFlight} + {1'b0, w_fifoCount}) < DEPTH_C);
    assign writeReady = !RST;
    assign w_accept   = readEnable && readReady;
    assign w_wrAccept = writeEnable && writeReady && ({1'b0, writeAddr} < ROWS_C);
    assign w_rdHit    = w_wrAccept && (writeAddr == readAddr);

    // New-data mode forwards the written lanes of a colliding write into the read word.
    always_comb begin
        w_rdWord = ({1'b0, readAddr} < ROWS_C) ? r_mem[readAddr] : '0;
        if ((wrMode == BRAM_WR_NEW) && w_rdHit) begin
            for (int i = 0; i < numLanes; i++) begin
                if (writeMask[i]) w_rdWord[i*LANE_W +: LANE_W] = writeData[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wrAccept) begin
            for (int i = 0; i < numLanes; i++) begin
                if (writeMask[i]) r_mem[writeAddr][i*LANE_W +: LANE_W] <= writeData[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) r_v0 <= 1'b0;
        else     r_v0 <= w_accept;
        if (w_accept) r_q0 <= w_rdWord;
    end

    if (outRegs == 1) begin : gOutReg
        logic                r_v1;
        logic [dataSize-1:0] r_q1;
        always_ff @(posedge CLK) begin
            if (RST) r_v1 <= 1'b0;
            else     r_v1 <= r_v0;
            if (r_v0) r_q1 <= r_q0;
        end
        assign w_lastValid = r_v1;
        assign w_lastData  = r_q1;
    end else begin : gNoOutReg
        assign w_lastValid = r_v0;
        assign w_lastData  = r_q0;
    end

    // The pipeline output bypasses the FIFO when it is empty; otherwise it queues behind older entries.
    assign readDataReady = !RST && (!w_fifoEmpty || w_lastValid);
    assign readData      = RST ? '0 : (!w_fifoEmpty ? w_fifoData : (w_lastValid ? w_lastData : '0));
    assign w_pop         = readDataEnable && readDataReady;
    assign w_fifoPop     = w_pop && !w_fifoEmpty;
    assign w_fifoPush    = w_lastValid && !(w_fifoEmpty && w_pop);

    bram_resp_fifo #(
        .dataSize (dataSize),
        .depth    (bufDepth)
    ) u_respFifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_fifoPush),
        .i_data  (w_lastData),
        .i_pop   (w_fifoPop),
        .o_data  (w_fifoData),
        .o_empty (w_fifoEmpty),
        .o_count (w_fifoCount)
    );

    assign w_inFlightNext = r_inFlight + CNT_W'(w_accept) - CNT_W'(w_lastValid);
    assign w_countNext    = w_fifoCount + CNT_W'(w_fifoPush) - CNT_W'(w_fifoPop);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_inFlight  <= '0;
            r_noPending <= 1'b1;
        end else begin
            r_inFlight  <= w_inFlightNext;
            r_noPending <= (w_inFlightNext == '0) && (w_countNext == '0);
        end
    end

    assign noPendingBool = RST || r_noPending;

endmodule

// File: tb/tb_bram_buffered.sv
// Scoreboard bench: two instances (outRegs 0/wrMode old, outRegs 1/wrMode new) share one stimulus stream.
module tb_bram_buffered;
    localparam int ROWS  = 512;
    localparam int DEPTH = 4;
    localparam int LAT [2] = '{1, 2};
    localparam int WRM [2] = '{0, 1};

    logic        CLK = 1'b0;
    logic        RST;
    logic        readEnable, readDataEnable, writeEnable;
    logic [8:0]  readAddr, writeAddr;
    logic [31:0] writeData;
    logic [3:0]  writeMask;
    logic        rdyA [2];
    logic        dvA  [2];
    logic        wrA  [2];
    logic        npA  [2];
    logic [31:0] dataA [2];

    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    int          acc [2] = '{0, 0};
    int          pops [2] = '{0, 0};
    int          lastAcc [2] = '{0, 0};
    int          lastPop [2] = '{0, 0};
    logic [31:0] lastData [2];
    logic [31:0] model [ROWS];
    logic [31:0] sb [2][$];
    logic [31:0] expWord;

    always #5 CLK = ~CLK;

    bram_buffered #(.outRegs(0), .bufDepth(DEPTH), .wrMode(0)) dut0 (
        .CLK(CLK), .RST(RST), .readEnable(readEnable), .readAddr(readAddr), .readReady(rdyA[0]),
        .readData(dataA[0]), .readDataEnable(readDataEnable), .readDataReady(dvA[0]),
        .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData), .writeMask(writeMask),
        .writeReady(wrA[0]), .noPendingBool(npA[0]));

    bram_buffered #(.outRegs(1), .bufDepth(DEPTH), .wrMode(1)) dut1 (
        .CLK(CLK), .RST(RST), .readEnable(readEnable), .readAddr(readAddr), .readReady(rdyA[1]),
        .readData(dataA[1]), .readDataEnable(readDataEnable), .readDataReady(dvA[1]),
        .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData), .writeMask(writeMask),
        .writeReady(wrA[1]), .noPendingBool(npA[1]));

    // Mid-cycle monitor: pops compare against the scoreboard, accepts push the model's expected word.
    always @(negedge CLK) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (RST) begin
                sb[k].delete();
            end else begin
                if (readDataEnable && dvA[k]) begin
                    compared++;
                    if (sb[k].size() == 0) begin
                        mismatched++;
                        $display("[TB] FAIL resp%0d unexpected: got %h, required no response", k, dataA[k]);
                    end else begin
                        expWord = sb[k].pop_front();
                        if (dataA[k] !== expWord) begin
                            mismatched++;
                            $display("[TB] FAIL resp%0d data: got %h, required %h", k, dataA[k], expWord);
                        end
                    end
                    pops[k]++;
                    lastPop[k]  = cyc;
                    lastData[k] = dataA[k];
                end
                if (readEnable && rdyA[k]) begin
                    expWord = model[readAddr];
                    if (WRM[k] == 1 && writeEnable && writeAddr == readAddr) begin
                        for (int i = 0; i < 4; i++)
                            if (writeMask[i]) expWord[i*8 +: 8] = writeData[i*8 +: 8];
                    end
                    sb[k].push_back(expWord);
                    acc[k]++;
                    lastAcc[k] = cyc;
                end
            end
        end
        if (!RST && writeEnable) begin
            for (int i = 0; i < 4; i++)
                if (writeMask[i]) model[writeAddr][i*8 +: 8] = writeData[i*8 +: 8];
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
        writeEnable = 1'b1; writeAddr = a; writeData = d; writeMask = m;
        tick();
        writeEnable = 1'b0; writeMask = 4'h0;
    endtask

    task automatic waitPops(input int t0, input int t1, output bit ok);
        int n;
        n = 0;
        while ((pops[0] < t0 || pops[1] < t1) && n < 60) begin
            tick();
            n++;
        end
        ok = (pops[0] >= t0) && (pops[1] >= t1);
    endtask

    task automatic test_reset();
        RST = 1'b1; readEnable = 1'b0; readDataEnable = 1'b0; writeEnable = 1'b0;
        readAddr = '0; writeAddr = '0; writeData = '0; writeMask = '0;
        @(negedge CLK); #1;
        for (int k = 0; k < 2; k++) begin
            compared++; if (rdyA[k] !== 1'b0) begin mismatched++; $display("[TB] FAIL rst%0d readReady: got %b, required 0", k, rdyA[k]); end
            compared++; if (wrA[k] !== 1'b0) begin mismatched++; $display("[TB] FAIL rst%0d writeReady: got %b, required 0", k, wrA[k]); end
            compared++; if (dvA[k] !== 1'b0) begin mismatched++; $display("[TB] FAIL rst%0d readDataReady: got %b, required 0", k, dvA[k]); end
            compared++; if (dataA[k] !== 32'h0) begin mismatched++; $display("[TB] FAIL rst%0d readData: got %h, required 0", k, dataA[k]); end
            compared++; if (npA[k] !== 1'b1) begin mismatched++; $display("[TB] FAIL rst%0d noPending: got %b, required 1", k, npA[k]); end
        end
        tick();
        RST = 1'b0;
        @(negedge CLK); #1;
        for (int k = 0; k < 2; k++) begin
            compared++; if (rdyA[k] !== 1'b1) begin mismatched++; $display("[TB] FAIL post-rst%0d readReady: got %b, required 1", k, rdyA[k]); end
            compared++; if (wrA[k] !== 1'b1) begin mismatched++; $display("[TB] FAIL post-rst%0d writeReady: got %b, required 1", k, wrA[k]); end
            compared++; if (dvA[k] !== 1'b0) begin mismatched++; $display("[TB] FAIL post-rst%0d readDataReady: got %b, required 0", k, dvA[k]); end
            compared++; if (npA[k] !== 1'b1) begin mismatched++; $display("[TB] FAIL post-rst%0d noPending: got %b, required 1", k, npA[k]); end
        end
        tick();
    endtask

    task automatic test_basic();
        int p0, p1;
        bit ok;
        applyStimulus(9'd5, 32'hDEADBEEF, 4'hF);
        p0 = pops[0]; p1 = pops[1];
        readDataEnable = 1'b1; readEnable = 1'b1; readAddr = 9'd5;
        tick();
        readEnable = 1'b0;
        @(negedge CLK); #1;
        for (int k = 0; k < 2; k++) begin
            compared++; if (npA[k] !== 1'b0) begin mismatched++; $display("[TB] FAIL basic%0d noPending after accept: got %b, required 0", k, npA[k]); end
        end
        waitPops(p0 + 1, p1 + 1, ok);
        compared++; if (!ok) begin mismatched++; $display("[TB] FAIL basic timeout: pops %0d/%0d, required %0d/%0d", pops[0], pops[1], p0 + 1, p1 + 1); end
        for (int k = 0; k < 2; k++) begin
            compared++; if (lastData[k] !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL basic%0d data: got %h, required deadbeef", k, lastData[k]); end
            compared++; if (lastPop[k] - lastAcc[k] != LAT[k]) begin mismatched++; $display("[TB] FAIL basic%0d latency: got %0d, required %0d", k, lastPop[k] - lastAcc[k], LAT[k]); end
        end
        tick(); tick();
        @(negedge CLK); #1;
        for (int k = 0; k < 2; k++) begin
            compared++; if (npA[k] !== 1'b1) begin mismatched++; $display("[TB] FAIL basic%0d noPending drained: got %b, required 1", k, npA[k]); end
        end
        tick();
    endtask

    task automatic test_mask();
        int p0, p1;
        bit ok;
        applyStimulus(9'd7, 32'h11223344, 4'hF);
        applyStimulus(9'd7, 32'hAABBCCDD, 4'b0101);
        applyStimulus(9'd7, 32'hFFFFFFFF, 4'b0000);
        p0 = pops[0]; p1 = pops[1];
        readDataEnable = 1'b1; readEnable = 1'b1; readAddr = 9'd7;
        tick();
        readEnable = 1'b0;
        waitPops(p0 + 1, p1 + 1, ok);
        compared++; if (!ok) begin mismatched++; $display("[TB] FAIL mask timeout: pops %0d/%0d", pops[0], pops[1]); end
        for (int k = 0; k < 2; k++) begin
            compared++; if (lastData[k] !== 32'h11BB33DD) begin mismatched++; $display("[TB] FAIL mask%0d data: got %h, required 11bb33dd", k, lastData[k]); end
        end
        tick();
    endtask

    task automatic test_same_cycle();
        int p0, p1;
        bit ok;
        applyStimulus(9'd3, 32'h0, 4'hF);
        p0 = pops[0]; p1 = pops[1];
        readDataEnable = 1'b1; readEnable = 1'b1; readAddr = 9'd3;
        writeEnable = 1'b1; writeAddr = 9'd3; writeData = 32'h5A5A5A5A; writeMask = 4'hF;
        tick();
        readEnable = 1'b0; writeEnable = 1'b0; writeMask = 4'h0;
        waitPops(p0 + 1, p1 + 1, ok);
        compared++; if (!ok) begin mismatched++; $display("[TB] FAIL rdw timeout: pops %0d/%0d", pops[0], pops[1]); end
        compared++; if (lastData[0] !== 32'h0) begin mismatched++; $display("[TB] FAIL rdw old-mode data: got %h, required 00000000", lastData[0]); end
        compared++; if (lastData[1] !== 32'h5A5A5A5A) begin mismatched++; $display("[TB] FAIL rdw new-mode data: got %h, required 5a5a5a5a", lastData[1]); end
        p0 = pops[0]; p1 = pops[1];
        readEnable = 1'b1; readAddr = 9'd3;
        tick();
        readEnable = 1'b0;
        waitPops(p0 + 1, p1 + 1, ok);
        compared++; if (!ok) begin mismatched++; $display("[TB] FAIL rdw reread timeout: pops %0d/%0d", pops[0], pops[1]); end
        for (int k = 0; k < 2; k++) begin
            compared++; if (lastData[k] !== 32'h5A5A5A5A) begin mismatched++; $display("[TB] FAIL rdw%0d reread: got %h, required 5a5a5a5a", k, lastData[k]); end
        end
        tick();
    endtask

    task automatic test_credits();
        int a0, a1, p0, p1;
        bit ok;
        for (int i = 16; i < 26; i++) applyStimulus(9'(i), 32'hC0DE0000 + 32'(i), 4'hF);
        a0 = acc[0]; a1 = acc[1]; p0 = pops[0]; p1 = pops[1];
        readDataEnable = 1'b0; readEnable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            readAddr = 9'(16 + i);
            tick();
        end
        @(negedge CLK); #1;
        compared++; if (acc[0] - a0 != DEPTH || acc[1] - a1 != DEPTH) begin mismatched++; $display("[TB] FAIL credit fill accepts: got %0d/%0d, required %0d", acc[0] - a0, acc[1] - a1, DEPTH); end
        for (int k = 0; k < 2; k++) begin
            compared++; if (rdyA[k] !== 1'b0) begin mismatched++; $display("[TB] FAIL credit%0d full readReady: got %b, required 0", k, rdyA[k]); end
        end
        tick();
        readDataEnable = 1'b1;
        @(negedge CLK); #1;
        for (int k = 0; k < 2; k++) begin
            compared++; if (rdyA[k] !== 1'b0) begin mismatched++; $display("[TB] FAIL credit%0d pop-cycle readReady: got %b, required 0", k, rdyA[k]); end
        end
        tick();
        readDataEnable = 1'b0;
        @(negedge CLK); #1;
        for (int k = 0; k < 2; k++) begin
            compared++; if (rdyA[k] !== 1'b1) begin mismatched++; $display("[TB] FAIL credit%0d freed readReady: got %b, required 1", k, rdyA[k]); end
        end
        compared++; if (acc[0] - a0 != DEPTH + 1 || acc[1] - a1 != DEPTH + 1) begin mismatched++; $display("[TB] FAIL credit refill accepts: got %0d/%0d, required %0d", acc[0] - a0, acc[1] - a1, DEPTH + 1); end
        tick();
        readEnable = 1'b0;
        @(negedge CLK); #1;
        for (int k = 0; k < 2; k++) begin
            compared++; if (rdyA[k] !== 1'b0) begin mismatched++; $display("[TB] FAIL credit%0d refull readReady: got %b, required 0", k, rdyA[k]); end
        end
        tick();
        readDataEnable = 1'b1;
        waitPops(p0 + DEPTH + 1, p1 + DEPTH + 1, ok);
        compared++; if (!ok) begin mismatched++; $display("[TB] FAIL credit drain timeout: pops %0d/%0d", pops[0], pops[1]); end
        tick();
    endtask

    task automatic test_back_to_back();
        int start [2];
        int first [2];
        int last  [2];
        int prev  [2];
        int stalls;
        for (int i = 0; i < 16; i++) applyStimulus(9'(i), 32'hB0B00000 + 32'(i * 17), 4'hF);
        stalls = 0;
        for (int k = 0; k < 2; k++) begin start[k] = pops[k]; prev[k] = pops[k]; first[k] = -1; last[k] = -1; end
        readDataEnable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            readEnable = (i < 16);
            readAddr   = 9'(i % 16);
            @(negedge CLK); #1;
            for (int k = 0; k < 2; k++) begin
                if (i < 16 && rdyA[k] !== 1'b1) stalls++;
                if (pops[k] != prev[k]) begin
                    if (first[k] < 0) first[k] = cyc;
                    last[k] = cyc;
                    prev[k] = pops[k];
                end
            end
            tick();
        end
        readEnable = 1'b0;
        compared++; if (stalls != 0) begin mismatched++; $display("[TB] FAIL b2b readReady stalls: got %0d, required 0", stalls); end
        for (int k = 0; k < 2; k++) begin
            compared++; if (pops[k] - start[k] != 16) begin mismatched++; $display("[TB] FAIL b2b%0d responses: got %0d, required 16", k, pops[k] - start[k]); end
            compared++; if (last[k] - first[k] != 15) begin mismatched++; $display("[TB] FAIL b2b%0d span: got %0d, required 15", k, last[k] - first[k]); end
        end
    endtask

    task automatic test_reset_midop();
        int stale, p0, p1;
        bit ok;
        readDataEnable = 1'b0; readEnable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            readAddr = 9'(i);
            tick();
        end
        RST = 1'b1;
        @(negedge CLK); #1;
        for (int k = 0; k < 2; k++) begin
            compared++; if (dvA[k] !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst%0d readDataReady: got %b, required 0", k, dvA[k]); end
            compared++; if (npA[k] !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst%0d noPending: got %b, required 1", k, npA[k]); end
        end
        tick();
        RST = 1'b0; readEnable = 1'b0; readDataEnable = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK); #1;
            for (int k = 0; k < 2; k++) if (dvA[k] !== 1'b0 || npA[k] !== 1'b1) stale++;
            tick();
        end
        compared++; if (stale != 0) begin mismatched++; $display("[TB] FAIL midrst stale state cycles: got %0d, required 0", stale); end
        p0 = pops[0]; p1 = pops[1];
        readEnable = 1'b1; readAddr = 9'd10;
        tick();
        readEnable = 1'b0;
        waitPops(p0 + 1, p1 + 1, ok);
        compared++; if (!ok) begin mismatched++; $display("[TB] FAIL midrst reread timeout: pops %0d/%0d", pops[0], pops[1]); end
        for (int k = 0; k < 2; k++) begin
            compared++; if (lastData[k] !== 32'hB0B000AA) begin mismatched++; $display("[TB] FAIL midrst%0d ram retained: got %h, required b0b000aa", k, lastData[k]); end
        end
        tick(); tick(); tick();
        @(negedge CLK); #1;
        for (int k = 0; k < 2; k++) begin
            compared++; if (sb[k].size() != 0 || npA[k] !== 1'b1) begin mismatched++; $display("[TB] FAIL final%0d drain: outstanding %0d noPending %b, required 0 and 1", k, sb[k].size(), npA[k]); end
        end
    endtask

    initial begin
        for (int i = 0; i < ROWS; i++) model[i] = 32'h0;
        test_reset();
        test_basic();
        test_mask();
        test_same_cycle();
        test_credits();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion before 100000ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
